// File: rtl/tx_frame_queue.sv
// tx_frame_queue: circular buffer of Hamming(7,4) codewords feeding a
// UART transmitter through a launch / busy-handshake state machine.
module tx_frame_queue #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [6:0] push_data,
    input  logic       flush,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] level,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] LVL_MAX = 4'(DEPTH);
    localparam logic [7:0] TMO     = 8'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       tmo_cnt;
    logic [7:0]       tmo_cnt_next;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic             tmo_hit;

    assign empty = (level == 4'd0);
    assign full  = (level == LVL_MAX);
    // A full queue still accepts a push when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Next-state and launch decode; the timeout count only runs in WAIT_BUSY.
    always_comb begin
        state_next   = state;
        tx_start     = 1'b0;
        pop          = 1'b0;
        tmo_hit      = 1'b0;
        tmo_cnt_next = 8'd0;
        unique case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start   = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if ((tmo_cnt + 8'd1) == TMO) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Launch FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointer and level bookkeeping; flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 4'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                level <= level + 4'd1;
            end else if (!wr_en && pop) begin
                level <= level - 4'd1;
            end
        end
    end

    // Codeword storage, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Frame register, timeout counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data     <= 8'h00;
            tmo_cnt     <= 8'd0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_next;
            if (pop) begin
                tx_data <= {1'b0, mem[rd_ptr]};
            end
            if (drop && !flush) begin
                overflow <= 1'b1;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_queue.sv
// tb_tx_frame_queue: directed checks of the frame queue with a small
// reactive model of the UART busy flag.
module tb_tx_frame_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [6:0] push_data;
    logic       flush;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit auto_busy = 0;
    logic [7:0] sent[$];
    int start_cyc[$];

    tx_frame_queue #(.DEPTH(4), .BUSY_TIMEOUT(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .push_data(push_data),
        .flush(flush),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .level(level),
        .empty(empty),
        .full(full),
        .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample just after the edge, log launches, model tx_busy.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            chk("busy_low_before_start", tx_busy, 0);
            sent.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (auto_busy) busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (auto_busy) tx_busy = (busy_cnt != 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_push(input logic [6:0] d);
        push = 1'b1;
        push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
    endtask

    initial begin
        bit got;
        rst_n = 1'b0;
        push = 1'b0;
        push_data = 7'h00;
        flush = 1'b0;
        tx_busy = 1'b0;
        ticks(2);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Basic launch: start two cycles after push.
        auto_busy = 1;
        sent.delete();
        do_push(7'h55);
        chk("b_level1", level, 1);
        chk("b_nostart", tx_start, 0);
        tick();
        chk("b_start", tx_start, 1);
        chk("b_data", tx_data, 8'h55);
        chk("b_level0", level, 0);
        tick();
        chk("b_pulse_end", tx_start, 0);
        ticks(20);
        chk("b_count", sent.size(), 1);
        chk("b_timeout", timeout_err, 0);

        // Fill while busy, overflow, then push on the pop edge of a full queue.
        auto_busy = 0;
        tx_busy = 1'b1;
        sent.delete();
        do_push(7'h11);
        do_push(7'h22);
        do_push(7'h33);
        do_push(7'h44);
        chk("f_full4", full, 1);
        chk("f_ovf_not_yet", overflow, 0);
        do_push(7'h5A);
        chk("f_level", level, 4);
        chk("f_ovf", overflow, 1);
        tx_busy = 1'b0;
        auto_busy = 1;
        push = 1'b1;
        push_data = 7'h66;
        tick();
        push = 1'b0;
        chk("f_start", tx_start, 1);
        chk("f_head", tx_data, 8'h11);
        chk("f_level_hold", level, 4);
        ticks(100);
        chk("f_count", sent.size(), 5);
        if (sent.size() == 5) begin
            chk("f_o0", sent[0], 8'h11);
            chk("f_o1", sent[1], 8'h22);
            chk("f_o2", sent[2], 8'h33);
            chk("f_o3", sent[3], 8'h44);
            chk("f_o4", sent[4], 8'h66);
        end
        chk("f_empty", empty, 1);
        chk("f_ovf_sticky", overflow, 1);

        // Back-to-back frames paced by the busy model.
        sent.delete();
        start_cyc.delete();
        do_push(7'h01);
        do_push(7'h02);
        do_push(7'h03);
        ticks(60);
        chk("bb_count", sent.size(), 3);
        if (sent.size() == 3) begin
            chk("bb_o0", sent[0], 8'h01);
            chk("bb_o1", sent[1], 8'h02);
            chk("bb_o2", sent[2], 8'h03);
            chk("bb_gap1", start_cyc[1] - start_cyc[0], 12);
            chk("bb_gap2", start_cyc[2] - start_cyc[1], 12);
        end

        // Timeout with tx_busy stuck low.
        auto_busy = 0;
        tx_busy = 1'b0;
        do_push(7'h0F);
        chk("t_err0", timeout_err, 0);
        ticks(16);
        chk("t_err_early", timeout_err, 0);
        tick();
        chk("t_err_set", timeout_err, 1);
        auto_busy = 1;
        do_push(7'h2A);
        tick();
        chk("t_relaunch", tx_start, 1);
        chk("t_relaunch_data", tx_data, 8'h2A);
        ticks(20);
        chk("t_err_sticky", timeout_err, 1);

        // Flush during WAIT_DONE after pointers have wrapped.
        sent.delete();
        do_push(7'h61);
        do_push(7'h62);
        do_push(7'h63);
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (tx_start) got = 1;
        end
        chk("fl_second_start", got, 1);
        chk("fl_second_data", tx_data, 8'h62);
        do_push(7'h71);
        do_push(7'h72);
        do_push(7'h73);
        chk("fl_level4", level, 4);
        chk("fl_full", full, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_level0", level, 0);
        chk("fl_empty", empty, 1);
        chk("fl_data_kept", tx_data, 8'h62);
        ticks(40);
        chk("fl_count", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("fl_o0", sent[0], 8'h61);
            chk("fl_o1", sent[1], 8'h62);
        end

        // Reset while two entries wait and a frame is in WAIT_DONE.
        sent.delete();
        do_push(7'h41);
        do_push(7'h42);
        do_push(7'h43);
        tick();
        chk("r_level2", level, 2);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("rmid");
        rst_n = 1'b1;
        auto_busy = 0;
        busy_cnt = 0;
        tx_busy = 1'b0;
        sent.delete();
        ticks(30);
        chk("r_no_start", sent.size(), 0);
        do_push(7'h3C);
        tick();
        chk("r_new_start", tx_start, 1);
        chk("r_new_data", tx_data, 8'h3C);
        ticks(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_queue.md
TX_FRAME_QUEUE -- requirements
Module: tx_frame_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 7-bit codeword entries; legal values are 2, 4 or 8.
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 15, meaning the number of cycles to wait for tx_busy to rise after launch; legal range is 1..255.
REQ-003 The block SHALL have port clk  in  1  system clock; every register updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port push  in  1  write strobe from the Hamming encoder valid pulse.
REQ-006 The block SHALL have port push_data  in  7  Hamming(7,4) codeword to enqueue.
REQ-007 The block SHALL have port flush  in  1  synchronous queue clear.
REQ-008 The block SHALL have port tx_busy  in  1  busy flag from the UART transmitter.
REQ-009 The block SHALL have port tx_start  out  1  one-cycle launch pulse to the UART transmitter.
REQ-010 The block SHALL have port tx_data  out  8  registered frame {1'b0, codeword}, held stable from launch until the next launch.
REQ-011 The block SHALL have port level  out  4  current number of stored entries.
REQ-012 The block SHALL have port empty and port full, each  out  1, decoded from level (level==0, level==DEPTH).
REQ-013 The block SHALL have port overflow  out  1  sticky flag: a push was dropped.
REQ-014 The block SHALL have port timeout_err  out  1  sticky flag: tx_busy was never seen after a launch.

Function
REQ-015 Storage SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 A push while not full SHALL write push_data at the write pointer, advance the write pointer, and increment level on the same edge.
REQ-017 A push while full with no pop on the same edge SHALL be dropped, leave queue contents unchanged, and set overflow.
REQ-018 A push while full with a pop on the same edge SHALL be accepted, leaving level unchanged at DEPTH.
REQ-019 A push and a pop on the same edge while not full and not empty SHALL leave level unchanged and advance both pointers.
REQ-020 The launch FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-021 In IDLE, when !empty && !tx_busy, the FSM SHALL pop the head entry on that edge, load tx_data <= {1'b0, head}, and move to LAUNCH.
REQ-022 In LAUNCH, tx_start SHALL be 1 for exactly that one cycle, and the FSM SHALL go to WAIT_BUSY unconditionally.
REQ-023 tx_start SHALL be 0 in every state other than LAUNCH.
REQ-024 In WAIT_BUSY, if tx_busy=1 the FSM SHALL go to WAIT_DONE.
REQ-025 In WAIT_BUSY, otherwise a cycle counter SHALL increment; on reaching BUSY_TIMEOUT the FSM SHALL set timeout_err and go to IDLE, and the frame SHALL be lost (no retry).
REQ-026 In WAIT_DONE, when tx_busy=0 the FSM SHALL go to IDLE.
REQ-027 Latency: a push sampled at edge N into an empty queue, with the FSM in IDLE and tx_busy=0, SHALL produce tx_start=1 in the cycle following edge N+1.
REQ-028 The minimum spacing between consecutive tx_start pulses SHALL be 4 cycles.
REQ-029 flush=1 SHALL zero both pointers and level on that edge, and SHALL take priority over a simultaneous push or pop.
REQ-030 flush SHALL NOT alter the FSM state, tx_data, or the sticky flags; an in-flight frame completes normally.
REQ-031 overflow and timeout_err SHALL clear only on reset.

Reset
REQ-032 On rst_n=0 at a clock edge, the block SHALL set FSM=IDLE, pointers=0, level=0, empty=1, full=0, tx_start=0, tx_data=8'h00, overflow=0, timeout_err=0, and the timeout counter to 0.
REQ-033 Reset asserted mid-transmission SHALL abandon all queued and in-flight frames; no tx_start SHALL occur until a new push after reset deassertion.
REQ-034 Stored RAM contents need not be cleared by reset.

Verification
REQ-035 Basic launch: push 7'h55 with tx_busy=0 -> tx_start pulse 2 cycles later, tx_data=8'h55, level back to 0.
REQ-036 Fill/overflow: with tx_busy held at 1, push 5 words (DEPTH=4) -> full=1, level=4, overflow=1; after busy releases, words 1-4 are sent in order and the 5th is never sent.
REQ-037 Back-to-back: push 3 words; model tx_busy high 10 cycles after each tx_start -> three tx_start pulses, each only after tx_busy falls, in FIFO order.
REQ-038 Timeout: push 7'h0F with tx_busy stuck at 0 -> timeout_err=1 after BUSY_TIMEOUT+2 cycles, FSM returns to IDLE, next push still launches.
REQ-039 Flush/wrap: push 3 words, pop 2, push 3 more to cross pointer wrap, then flush during WAIT_DONE -> level=0, the current frame completes, no further tx_start occurs.
REQ-040 Reset mid-op: assert rst_n=0 while level=2 in WAIT_DONE -> all outputs equal their reset values on the next edge, and no tx_start occurs afterwards without a new push.
